// File: rtl/collision_event_generator_pkg.sv
// Shared constants and types for the collision event generator.
// Holds the default cooldown length and the scoring FSM state encoding.
package collision_event_generator_pkg;

  localparam int unsigned COLLISION_COOLDOWN_FRAMES = 4;

  typedef enum logic [1:0] {
    CE_IDLE     = 2'd0,
    CE_CONTACT  = 2'd1,
    CE_COOLDOWN = 2'd2
  } ce_state_e;

endpackage

// File: rtl/collision_event_generator_frame_sticky_flag.sv
// Per-frame sticky overlap flag with a registered first-hit pulse.
// A hit on the startOfFrame cycle belongs to the new frame (set after clear).
module frame_sticky_flag (
  input  logic clk,
  input  logic resetN,
  input  logic start_of_frame,
  input  logic clear,
  input  logic pixel_hit,
  output logic flag,
  output logic first_hit
);

  logic flag_q;
  logic first_hit_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flag_q      <= 1'b0;
      first_hit_q <= 1'b0;
    end else if (clear) begin
      flag_q      <= 1'b0;
      first_hit_q <= 1'b0;
    end else begin
      flag_q      <= start_of_frame ? pixel_hit : (flag_q | pixel_hit);
      first_hit_q <= pixel_hit & (start_of_frame | ~flag_q);
    end
  end

  assign flag      = flag_q;
  assign first_hit = first_hit_q;

endmodule

// File: rtl/collision_event_generator.sv
// Turns per-pixel smiley/border/obstacle overlaps into frame-aligned event pulses,
// including a scoring pulse gated by contact episodes and a frame cooldown.
module collision_event_generator
  import collision_event_generator_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = COLLISION_COOLDOWN_FRAMES
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic pause,
  input  logic smileyDrawingRequest,
  input  logic borderBottomDrawingRequest,
  input  logic obstacleDrawingRequest,
  output logic collisionSmileyBorderBottom,
  output logic collisionSmileyObstacle,
  output logic collisionSmileyObstacleReal
);

  localparam int unsigned CdW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CdW-1:0] CdInit =
      (COOLDOWN_FRAMES > 1) ? CdW'(COOLDOWN_FRAMES - 1) : '0;

  logic pix_bottom, pix_obst;
  logic hit_bottom, hit_obst;
  logic unused_bottom_first_hit;
  logic obst_first_hit;

  assign pix_bottom = smileyDrawingRequest & borderBottomDrawingRequest;
  assign pix_obst   = smileyDrawingRequest & obstacleDrawingRequest;

  frame_sticky_flag u_bottom_flag (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (startOfFrame),
    .clear          (pause),
    .pixel_hit      (pix_bottom),
    .flag           (hit_bottom),
    .first_hit      (unused_bottom_first_hit)
  );

  frame_sticky_flag u_obst_flag (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (startOfFrame),
    .clear          (pause),
    .pixel_hit      (pix_obst),
    .flag           (hit_obst),
    .first_hit      (obst_first_hit)
  );

  ce_state_e      state_q;
  logic [CdW-1:0] cd_q, cd_dec;
  logic           bottom_q, real_q;

  always_comb begin
    cd_dec = '0;
    if (cd_q != '0) cd_dec = cd_q - CdW'(1);
  end

  // Cooldown counts frames since the scoring hit, regardless of contact in between.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= CE_IDLE;
      cd_q     <= '0;
      bottom_q <= 1'b0;
      real_q   <= 1'b0;
    end else if (pause) begin
      state_q  <= CE_IDLE;
      cd_q     <= '0;
      bottom_q <= 1'b0;
      real_q   <= 1'b0;
    end else begin
      bottom_q <= startOfFrame & hit_bottom;
      real_q   <= 1'b0;
      if (startOfFrame) begin
        unique case (state_q)
          CE_IDLE: begin
            if (hit_obst) begin
              real_q  <= 1'b1;
              cd_q    <= CdInit;
              state_q <= CE_CONTACT;
            end
          end
          CE_CONTACT: begin
            cd_q <= cd_dec;
            if (!hit_obst) begin
              if (cd_dec == '0) state_q <= CE_IDLE;
              else              state_q <= CE_COOLDOWN;
            end
          end
          CE_COOLDOWN: begin
            cd_q <= cd_dec;
            if (hit_obst)             state_q <= CE_CONTACT;
            else if (cd_dec == '0)    state_q <= CE_IDLE;
          end
          default: begin
            state_q <= CE_IDLE;
            cd_q    <= '0;
          end
        endcase
      end
    end
  end

  assign collisionSmileyBorderBottom = bottom_q;
  assign collisionSmileyObstacle     = obst_first_hit;
  assign collisionSmileyObstacleReal = real_q;

endmodule

// File: tb/tb_collision_event_generator.sv
// Bench for collision_event_generator: frame-level reference model checked every cycle,
// plus directed frame scenarios with hand-computed pulse counts and timings.
module tb_collision_event_generator;

  localparam int CF = 4;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic startOfFrame = 1'b0;
  logic pause = 1'b0;
  logic smileyDrawingRequest = 1'b0;
  logic borderBottomDrawingRequest = 1'b0;
  logic obstacleDrawingRequest = 1'b0;
  logic collisionSmileyBorderBottom;
  logic collisionSmileyObstacle;
  logic collisionSmileyObstacleReal;

  collision_event_generator #(.COOLDOWN_FRAMES(CF)) dut (
    .clk                         (clk),
    .resetN                      (resetN),
    .startOfFrame                (startOfFrame),
    .pause                       (pause),
    .smileyDrawingRequest        (smileyDrawingRequest),
    .borderBottomDrawingRequest  (borderBottomDrawingRequest),
    .obstacleDrawingRequest      (obstacleDrawingRequest),
    .collisionSmileyBorderBottom (collisionSmileyBorderBottom),
    .collisionSmileyObstacle     (collisionSmileyObstacle),
    .collisionSmileyObstacleReal (collisionSmileyObstacleReal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_b = 0, n_o = 0, n_r = 0;
  int s_b, s_o, s_r;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: frame bookkeeping plus the episode rule for scoring. A scoring pulse
  // needs contact in the finished frame and, since the previous scoring frame R, some
  // contact-free frame F with F >= R + CF - 1 (or no scoring since reset/pause).
  logic hit_b, hit_o;
  assign hit_b = smileyDrawingRequest & borderBottomDrawingRequest;
  assign hit_o = smileyDrawingRequest & obstacleDrawingRequest;

  logic m_fb = 1'b0, m_fo = 1'b0, m_have = 1'b0, m_ended = 1'b0;
  int   m_idx = 0, m_last = 0;
  logic e_b = 1'b0, e_o = 1'b0, e_r = 1'b0;

  always @(posedge clk) begin
    if (!resetN || pause) begin
      m_fb <= 1'b0; m_fo <= 1'b0; m_have <= 1'b0; m_ended <= 1'b0;
      m_idx <= 0; m_last <= 0;
      e_b <= 1'b0; e_o <= 1'b0; e_r <= 1'b0;
    end else begin
      e_o <= hit_o && (startOfFrame || !m_fo);
      if (startOfFrame) begin
        e_b   <= m_fb;
        m_idx <= m_idx + 1;
        m_fb  <= hit_b;
        m_fo  <= hit_o;
        if (m_fo && (!m_have || m_ended)) begin
          e_r <= 1'b1; m_have <= 1'b1; m_last <= m_idx; m_ended <= 1'b0;
        end else begin
          e_r <= 1'b0;
          if (!m_fo && m_have && (m_idx >= m_last + CF - 1)) m_ended <= 1'b1;
        end
      end else begin
        e_b  <= 1'b0;
        e_r  <= 1'b0;
        m_fb <= m_fb | hit_b;
        m_fo <= m_fo | hit_o;
      end
    end
  end

  always @(negedge clk) begin
    chk("bottom", collisionSmileyBorderBottom, resetN ? e_b : 1'b0);
    chk("obstacle", collisionSmileyObstacle, resetN ? e_o : 1'b0);
    chk("real", collisionSmileyObstacleReal, resetN ? e_r : 1'b0);
    if (collisionSmileyBorderBottom === 1'b1) n_b++;
    if (collisionSmileyObstacle === 1'b1) n_o++;
    if (collisionSmileyObstacleReal === 1'b1) n_r++;
  end

  // One frame of len pixels; windows are [start, start+n). Expected values < 0 are skipped.
  task automatic frame(input int len, input int bs, input int bn, input int os, input int on,
                       input int ps, input int pn, input int rs, input int rn,
                       input int eb, input int eo, input int er);
    for (int p = 0; p < len; p++) begin
      logic b_on, o_on, p_on, r_on;
      b_on = (p >= bs) && (p < bs + bn);
      o_on = (p >= os) && (p < os + on);
      p_on = (p >= ps) && (p < ps + pn);
      r_on = (p >= rs) && (p < rs + rn);
      startOfFrame = (p == 0);
      pause = p_on;
      resetN = !r_on;
      smileyDrawingRequest = b_on | o_on | (p == 1);
      borderBottomDrawingRequest = b_on | (p == len - 1);
      obstacleDrawingRequest = o_on | (p == len - 2);
      @(posedge clk);
      #1;
      if (p == 0) begin
        if (eb >= 0) chk("sof_bottom", collisionSmileyBorderBottom, eb[0]);
        if (eo >= 0) chk("sof_obstacle", collisionSmileyObstacle, eo[0]);
        if (er >= 0) chk("sof_real", collisionSmileyObstacleReal, er[0]);
      end
      if (p_on || r_on) begin
        chk("quiet_bottom", collisionSmileyBorderBottom, 1'b0);
        chk("quiet_obstacle", collisionSmileyObstacle, 1'b0);
        chk("quiet_real", collisionSmileyObstacleReal, 1'b0);
      end
    end
  endtask

  task automatic empties(input int n);
    for (int i = 0; i < n; i++) frame(16, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1);
  endtask

  task automatic snap();
    s_b = n_b; s_o = n_o; s_r = n_r;
  endtask

  task automatic counts(input string tag, input int b, input int o, input int r);
    chk_int({tag, "_bottom_count"}, n_b - s_b, b);
    chk_int({tag, "_obstacle_count"}, n_o - s_o, o);
    chk_int({tag, "_real_count"}, n_r - s_r, r);
  endtask

  initial begin
    #1 resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bottom", collisionSmileyBorderBottom, 1'b0);
    chk("reset_obstacle", collisionSmileyObstacle, 1'b0);
    chk("reset_real", collisionSmileyObstacleReal, 1'b0);
    empties(2);

    // Bottom overlap on 3 pixels.
    snap();
    frame(16, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    counts("bottom3", 1, 0, 0);

    // Obstacle overlap on 10 pixels.
    snap();
    frame(16, 0, 0, 3, 10, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    empties(5);
    counts("obst10", 0, 1, 1);

    // Contact in five consecutive frames.
    snap();
    frame(16, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) frame(16, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    empties(5);
    counts("contact5", 0, 5, 1);

    // Short release stays in cooldown, long release rearms scoring.
    snap();
    frame(16, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    empties(5);
    counts("rearm", 0, 3, 2);

    // Bottom and obstacle together, then overlaps on the startOfFrame cycle.
    snap();
    frame(16, 4, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    frame(16, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    empties(5);
    frame(16, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    empties(5);
    counts("same_frame", 2, 2, 2);

    // Pause in the middle of a contact episode.
    snap();
    frame(16, 0, 0, 2, 4, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 2, 10, 5, 4, 0, 0, 0, 0, 1);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    empties(5);
    counts("pause", 0, 3, 2);

    // Reset in the middle of a contact episode.
    snap();
    frame(16, 0, 0, 2, 4, 0, 0, 0, 0, 0, 0, 0);
    frame(16, 0, 0, 2, 10, 0, 0, 5, 2, 0, 0, 1);
    frame(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    empties(2);
    counts("reset_mid", 0, 3, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
